shift_unit: RTL and testbench
=============================

Name: shift_unit

Overview:
Multi-cycle, parametrised shifter for the ALU. It supersedes the fixed one-bit combinational left shift with selectable mode and shift amount. Shifts one bit position per clock and reports the result, carry-out and a zero flag through a start/busy/done handshake. The ALU issues it from the control FSM and waits on done.

Parameters:
WIDTH, 8, data width in bits (>=2)
AMT_W, 3, shift-amount width; must equal clog2(WIDTH)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset, synchronous, active-low
start  input  1  request; sampled only in IDLE
mode  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROL; sampled with start
amount  input  AMT_W  shift count 0..WIDTH-1; sampled with start
din  input  WIDTH  operand; sampled with start
busy  output  1  high in SHIFT and DONE
done  output  1  one-cycle pulse; result valid
dout  output  WIDTH  result register
carry  output  1  last bit shifted/rotated out; 0 if amount=0
zero  output  1  high when dout==0

Behaviour:
- Reset: synchronous, active-low. A clk edge with rst_n=0 forces state IDLE and clears dout=0, carry=0, busy=0, done=0, count=0. zero is combinational on dout, so it reads 1 in reset.
- Reset mid-operation aborts the shift. No done pulse is produced.
- States are IDLE, SHIFT and DONE.
- IDLE, start=1 at edge E0:
  - Latch din into dout, latch mode, load count=amount, clear carry.
  - If amount=0, next state is DONE; otherwise next state is SHIFT.
- IDLE, start=0: hold all outputs.
- SHIFT, each edge performs one single-bit step on dout and decrements count:
  - LSL: dout={dout[W-2:0],0}, carry=dout[W-1].
  - LSR: dout={0,dout[W-1:1]}, carry=dout[0].
  - ASR: dout={dout[W-1],dout[W-1:1]}, carry=dout[0].
  - ROL: dout={dout[W-2:0],dout[W-1]}, carry=dout[W-1].
  - The edge on which count goes 1->0 moves the state to DONE.
- DONE: done=1 for exactly one cycle, then IDLE on the next edge. dout and carry are held.
- Latency: for amount=N, done is high in the cycle following edge EN (E0 when N=0). busy rises after E0 and falls together with done.
- Handshake:
  - start is ignored in SHIFT and DONE; no queuing, and mode/amount/din changes have no effect.
  - start in the IDLE cycle right after DONE is accepted, giving back-to-back operation.
- dout, carry and zero hold their values in IDLE until the next accepted start.
- Width rule: amount never exceeds WIDTH-1 by construction. All arithmetic is unsigned except ASR sign replication.

Test Plan:
- Reset: rst_n=0 for 2 edges -> dout=00, carry=0, busy=0, done=0, zero=1. Release, idle 3 cycles -> outputs unchanged.
- LSL: din=B5, amount=1, mode=00, start at E0 -> busy after E0, done pulse after E1 only, dout=6A, carry=1, zero=0.
- LSR: din=81, amount=7, mode=01 -> done after E7 (busy 8 cycles including DONE), dout=01, carry=0.
- ASR: din=90, amount=3, mode=10 -> dout=F2, carry=0. ROL: din=81, amount=3, mode=11 -> dout=0C, carry=0.
- Zero count and handshake: din=00, amount=0 -> DONE after E0, dout=00, zero=1, carry=0.
  - Then start LSL din=FF amount=4 and pulse start again with din=00 during SHIFT -> second start ignored, result F0, carry=1.
  - start held high through DONE -> new operation accepted in the IDLE cycle.
- Abort: start LSR din=F0 amount=6, drive rst_n=0 at the third SHIFT edge -> IDLE, dout=00, no done pulse.
  - After release, start ASR din=80 amount=7 -> dout=FF, carry=0.

Source files
------------

// File: rtl/shift_unit.sv
// Multi-cycle shifter: LSL/LSR/ASR/ROL, one bit position per clock, with a
// start/busy/done handshake. Reports the result, the last bit shifted out and a zero flag.
module shift_unit #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [AMT_W-1:0] amount,
   input  logic [WIDTH-1:0] din,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] dout,
   output logic             carry,
   output logic             zero
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic [1:0] MODE_LSL = 2'b00;
   localparam logic [1:0] MODE_LSR = 2'b01;
   localparam logic [1:0] MODE_ASR = 2'b10;
   localparam logic [1:0] MODE_ROL = 2'b11;

   state_t           state_q, state_d;
   logic [AMT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] dout_q,  dout_d;
   logic             carry_q, carry_d;
   logic [1:0]       mode_q,  mode_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         dout_q  <= '0;
         carry_q <= 1'b0;
         mode_q  <= MODE_LSL;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         dout_q  <= dout_d;
         carry_q <= carry_d;
         mode_q  <= mode_d;
      end
   end

   // A zero-length request skips SHIFT and reports the untouched operand at once.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = (amount == '0) ? ST_DONE : ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (count_q == AMT_W'(1)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      count_d = count_q;
      dout_d  = dout_q;
      carry_d = carry_q;
      mode_d  = mode_q;
      if (state_q == ST_IDLE && start) begin
         dout_d  = din;
         mode_d  = mode;
         count_d = amount;
         carry_d = 1'b0;
      end else if (state_q == ST_SHIFT) begin
         count_d = count_q - AMT_W'(1);
         case (mode_q)
            MODE_LSL: begin
               dout_d  = {dout_q[WIDTH-2:0], 1'b0};
               carry_d = dout_q[WIDTH-1];
            end
            MODE_LSR: begin
               dout_d  = {1'b0, dout_q[WIDTH-1:1]};
               carry_d = dout_q[0];
            end
            MODE_ASR: begin
               dout_d  = {dout_q[WIDTH-1], dout_q[WIDTH-1:1]};
               carry_d = dout_q[0];
            end
            MODE_ROL: begin
               dout_d  = {dout_q[WIDTH-2:0], dout_q[WIDTH-1]};
               carry_d = dout_q[WIDTH-1];
            end
            default: begin
               dout_d  = dout_q;
               carry_d = carry_q;
            end
         endcase
      end
   end

   always_comb begin
      busy  = (state_q == ST_SHIFT) || (state_q == ST_DONE);
      done  = (state_q == ST_DONE);
      dout  = dout_q;
      carry = carry_q;
      zero  = (dout_q == '0);
   end

endmodule

// File: tb/tb_shift_unit.sv
// Directed bench for shift_unit: reset, each shift mode, zero-length request,
// ignored start during SHIFT, back-to-back issue and abort by reset.
module tb_shift_unit;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [1:0] mode;
   logic [2:0] amount;
   logic [7:0] din;
   logic       busy;
   logic       done;
   logic [7:0] dout;
   logic       carry;
   logic       zero;

   int total;
   int bad;

   shift_unit #(.WIDTH(8), .AMT_W(3)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .mode   (mode),
      .amount (amount),
      .din    (din),
      .busy   (busy),
      .done   (done),
      .dout   (dout),
      .carry  (carry),
      .zero   (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issues one request from IDLE at a negedge and waits (bounded) for done.
   // lat = negedges after the accepting edge until done is seen (-1 on timeout).
   task automatic do_op(input logic [1:0] m, input logic [2:0] a, input logic [7:0] d,
                        output int lat, output int busy_cycles);
      start  = 1'b1;
      mode   = m;
      amount = a;
      din    = d;
      @(negedge clk);
      start       = 1'b0;
      lat         = -1;
      busy_cycles = 0;
      for (int i = 0; i < 40; i++) begin
         if (busy) busy_cycles++;
         if (done) begin
            lat = i;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (dout !== 8'h00)  begin bad++; $display("FAIL reset_dout got=%h exp=00", dout); end
      total++; if (carry !== 1'b0)  begin bad++; $display("FAIL reset_carry got=%b exp=0", carry); end
      total++; if (busy !== 1'b0)   begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (done !== 1'b0)   begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
      total++; if (zero !== 1'b1)   begin bad++; $display("FAIL reset_zero got=%b exp=1", zero); end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (dout !== 8'h00)  begin bad++; $display("FAIL idle_dout got=%h exp=00", dout); end
      total++; if (busy !== 1'b0)   begin bad++; $display("FAIL idle_busy got=%b exp=0", busy); end
      total++; if (zero !== 1'b1)   begin bad++; $display("FAIL idle_zero got=%b exp=1", zero); end
   endtask

   task automatic test_lsl();
      int lat, bc;
      do_op(2'b00, 3'd1, 8'hB5, lat, bc);
      total++; if (lat !== 1)       begin bad++; $display("FAIL lsl_latency got=%0d exp=1", lat); end
      total++; if (dout !== 8'h6A)  begin bad++; $display("FAIL lsl_dout got=%h exp=6a", dout); end
      total++; if (carry !== 1'b1)  begin bad++; $display("FAIL lsl_carry got=%b exp=1", carry); end
      total++; if (zero !== 1'b0)   begin bad++; $display("FAIL lsl_zero got=%b exp=0", zero); end
      total++; if (bc !== 2)        begin bad++; $display("FAIL lsl_busy_cycles got=%0d exp=2", bc); end
      @(negedge clk);
      total++; if (done !== 1'b0)   begin bad++; $display("FAIL lsl_done_pulse got=%b exp=0", done); end
      total++; if (busy !== 1'b0)   begin bad++; $display("FAIL lsl_busy_fall got=%b exp=0", busy); end
      total++; if (dout !== 8'h6A)  begin bad++; $display("FAIL lsl_hold got=%h exp=6a", dout); end
   endtask

   task automatic test_lsr();
      int lat, bc;
      do_op(2'b01, 3'd7, 8'h81, lat, bc);
      total++; if (lat !== 7)       begin bad++; $display("FAIL lsr_latency got=%0d exp=7", lat); end
      total++; if (bc !== 8)        begin bad++; $display("FAIL lsr_busy_cycles got=%0d exp=8", bc); end
      total++; if (dout !== 8'h01)  begin bad++; $display("FAIL lsr_dout got=%h exp=01", dout); end
      total++; if (carry !== 1'b0)  begin bad++; $display("FAIL lsr_carry got=%b exp=0", carry); end
      @(negedge clk);
   endtask

   task automatic test_asr_rol();
      int lat, bc;
      do_op(2'b10, 3'd3, 8'h90, lat, bc);
      total++; if (lat !== 3)       begin bad++; $display("FAIL asr_latency got=%0d exp=3", lat); end
      total++; if (dout !== 8'hF2)  begin bad++; $display("FAIL asr_dout got=%h exp=f2", dout); end
      total++; if (carry !== 1'b0)  begin bad++; $display("FAIL asr_carry got=%b exp=0", carry); end
      @(negedge clk);
      do_op(2'b11, 3'd3, 8'h81, lat, bc);
      total++; if (lat !== 3)       begin bad++; $display("FAIL rol_latency got=%0d exp=3", lat); end
      total++; if (dout !== 8'h0C)  begin bad++; $display("FAIL rol_dout got=%h exp=0c", dout); end
      total++; if (carry !== 1'b0)  begin bad++; $display("FAIL rol_carry got=%b exp=0", carry); end
      @(negedge clk);
   endtask

   task automatic test_zero_amount();
      int lat, bc;
      // Prior result is nonzero with carry set, so a proper reload is visible.
      do_op(2'b00, 3'd1, 8'hC0, lat, bc);
      @(negedge clk);
      do_op(2'b00, 3'd0, 8'h00, lat, bc);
      total++; if (lat !== 0)       begin bad++; $display("FAIL zamt_latency got=%0d exp=0", lat); end
      total++; if (dout !== 8'h00)  begin bad++; $display("FAIL zamt_dout got=%h exp=00", dout); end
      total++; if (zero !== 1'b1)   begin bad++; $display("FAIL zamt_zero got=%b exp=1", zero); end
      total++; if (carry !== 1'b0)  begin bad++; $display("FAIL zamt_carry got=%b exp=0", carry); end
      @(negedge clk);
   endtask

   task automatic test_ignored_start();
      int lat;
      start = 1'b1; mode = 2'b00; amount = 3'd4; din = 8'hFF;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1; mode = 2'b01; amount = 3'd1; din = 8'h00;
      @(negedge clk);
      start = 1'b0;
      lat = -1;
      for (int i = 2; i < 40; i++) begin
         if (done) begin
            lat = i;
            break;
         end
         @(negedge clk);
      end
      total++; if (lat !== 4)       begin bad++; $display("FAIL ign_latency got=%0d exp=4", lat); end
      total++; if (dout !== 8'hF0)  begin bad++; $display("FAIL ign_dout got=%h exp=f0", dout); end
      total++; if (carry !== 1'b1)  begin bad++; $display("FAIL ign_carry got=%b exp=1", carry); end
      @(negedge clk);
      total++; if (busy !== 1'b0)   begin bad++; $display("FAIL ign_no_restart got=%b exp=0", busy); end
   endtask

   task automatic test_back_to_back();
      int lat;
      start = 1'b1; mode = 2'b00; amount = 3'd1; din = 8'h01;
      @(negedge clk);
      @(negedge clk);
      total++; if (done !== 1'b1)   begin bad++; $display("FAIL b2b_first_done got=%b exp=1", done); end
      total++; if (dout !== 8'h02)  begin bad++; $display("FAIL b2b_first_dout got=%h exp=02", dout); end
      // start stays high through DONE; new operands take effect in the next IDLE cycle.
      mode = 2'b11; amount = 3'd2; din = 8'hC0;
      @(negedge clk);
      total++; if (busy !== 1'b0)   begin bad++; $display("FAIL b2b_idle_gap got=%b exp=0", busy); end
      @(negedge clk);
      start = 1'b0;
      total++; if (busy !== 1'b1)   begin bad++; $display("FAIL b2b_accept got=%b exp=1", busy); end
      lat = -1;
      for (int i = 0; i < 40; i++) begin
         if (done) begin
            lat = i;
            break;
         end
         @(negedge clk);
      end
      total++; if (lat !== 2)       begin bad++; $display("FAIL b2b_latency got=%0d exp=2", lat); end
      total++; if (dout !== 8'h03)  begin bad++; $display("FAIL b2b_dout got=%h exp=03", dout); end
      total++; if (carry !== 1'b1)  begin bad++; $display("FAIL b2b_carry got=%b exp=1", carry); end
      @(negedge clk);
   endtask

   task automatic test_abort();
      int lat, bc, done_seen;
      start = 1'b1; mode = 2'b01; amount = 3'd6; din = 8'hF0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      total++; if (busy !== 1'b0)   begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
      total++; if (done !== 1'b0)   begin bad++; $display("FAIL abort_done got=%b exp=0", done); end
      total++; if (dout !== 8'h00)  begin bad++; $display("FAIL abort_dout got=%h exp=00", dout); end
      total++; if (zero !== 1'b1)   begin bad++; $display("FAIL abort_zero got=%b exp=1", zero); end
      rst_n = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done || busy) done_seen++;
      end
      total++; if (done_seen !== 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", done_seen); end
      do_op(2'b10, 3'd7, 8'h80, lat, bc);
      total++; if (lat !== 7)       begin bad++; $display("FAIL post_abort_latency got=%0d exp=7", lat); end
      total++; if (dout !== 8'hFF)  begin bad++; $display("FAIL post_abort_dout got=%h exp=ff", dout); end
      total++; if (carry !== 1'b0)  begin bad++; $display("FAIL post_abort_carry got=%b exp=0", carry); end
      @(negedge clk);
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      rst_n  = 1'b0;
      start  = 1'b0;
      mode   = 2'b00;
      amount = 3'd0;
      din    = 8'h00;
      @(negedge clk);
      test_reset();
      test_lsl();
      test_lsr();
      test_asr_rol();
      test_zero_amount();
      test_ignored_start();
      test_back_to_back();
      test_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
